// File: rtl/checker_pkg.sv
// Shared types for the result checker: run states, pipeline tag
// and the supported latency ceiling.
package checker_pkg;

  localparam int LAT_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] exp;
  } tag_t;

  function automatic tag_t make_tag(
    input logic       v,
    input logic [7:0] x,
    input logic [7:0] y
  );
    tag_t t;
    t.valid = v;
    t.exp   = x + y;
    return t;
  endfunction

endpackage

// File: rtl/result_checker_delay_line.sv
// Fixed-depth shift pipeline of expected-result tags; shifts every
// cycle, and a synchronous flush empties every stage at once.
module delay_line
  import checker_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  tag_t i_d,
  output tag_t o_q
);

  tag_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/result_checker.sv
// Result checker: scores a DUT's a+b results against a latency-matched
// expected-value pipeline and reports counts, sum and pass/fail.
module result_checker
  import checker_pkg::*;
#(
  parameter int          LAT  = 1,
  parameter logic [31:0] NVEC = 32'd256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        en,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  z,
  output logic [31:0] vectornum,
  output logic [31:0] errors,
  output logic [31:0] sum,
  output logic        mismatch,
  output logic        done,
  output logic        pass
);

  localparam int DEPTH =
    (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_vectornum;
  logic [31:0] r_errors;
  logic [31:0] r_sum;
  logic        r_mismatch;

  logic        w_restart;
  logic        w_cmp;
  logic        w_miss;
  logic        w_last;
  tag_t        w_push;
  tag_t        w_tap;

  // start is only honoured outside RUN
  assign w_restart = start && (r_state != RUN);
  assign w_cmp     = (r_state == RUN) && w_tap.valid;
  assign w_miss    = w_cmp && (z != w_tap.exp);
  assign w_last    = w_cmp && ((r_vectornum + 32'd1) == NVEC);
  assign w_push    = make_tag((r_state == RUN) && en, a, b);

  delay_line #(
    .DEPTH (DEPTH)
  ) u_tags (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_flush (w_restart),
    .i_d     (w_push),
    .o_q     (w_tap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_restart: w_state_nxt = RUN;
      w_last:    w_state_nxt = DONE;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vectornum <= '0;
      r_errors    <= '0;
      r_sum       <= '0;
    end else if (w_restart) begin
      r_vectornum <= '0;
      r_errors    <= '0;
      r_sum       <= '0;
    end else if (w_cmp) begin
      r_vectornum <= r_vectornum + 32'd1;
      r_sum       <= r_sum + {24'd0, z};
      if (w_miss && (r_errors != '1)) begin
        r_errors <= r_errors + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= w_miss && !w_restart;
    end
  end

  assign vectornum = r_vectornum;
  assign errors    = r_errors;
  assign sum       = r_sum;
  assign mismatch  = r_mismatch;
  assign done      = (r_state == DONE);
  assign pass      = (r_state == DONE) && (r_errors == '0);

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: two instances (LAT=1 and LAT=3) checked
// against a time-indexed behavioural model plus directed literals.
module tb_result_checker;

  logic        clk;
  logic        rst_n;
  logic        st [2];
  logic        en [2];
  logic [7:0]  a  [2];
  logic [7:0]  b  [2];
  logic [7:0]  z  [2];
  logic [31:0] vn [2];
  logic [31:0] er [2];
  logic [31:0] sm [2];
  logic        mm [2];
  logic        dn [2];
  logic        ps [2];

  int n_chk = 0;
  int n_err = 0;
  int mmcnt0 = 0;

  result_checker #(.LAT(1), .NVEC(32'd4)) u0 (
    .clk(clk), .reset_n(rst_n), .start(st[0]), .en(en[0]),
    .a(a[0]), .b(b[0]), .z(z[0]),
    .vectornum(vn[0]), .errors(er[0]), .sum(sm[0]),
    .mismatch(mm[0]), .done(dn[0]), .pass(ps[0])
  );

  result_checker #(.LAT(3), .NVEC(32'd4)) u1 (
    .clk(clk), .reset_n(rst_n), .start(st[1]), .en(en[1]),
    .a(a[1]), .b(b[1]), .z(z[1]),
    .vectornum(vn[1]), .errors(er[1]), .sum(sm[1]),
    .mismatch(mm[1]), .done(dn[1]), .pass(ps[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every push is logged by edge number; the compare at edge e
  // looks at the entry logged LAT edges earlier, unless a restart or
  // reset happened at or after the edge it was logged.
  int          lat [2] = '{1, 3};
  int          mst [2] = '{0, 0};
  logic [31:0] mvn [2] = '{0, 0};
  logic [31:0] merr[2] = '{0, 0};
  logic [31:0] msum[2] = '{0, 0};
  bit          mmm [2] = '{0, 0};
  int          fe  [2] = '{-1, -1};
  bit          hv  [2][256];
  logic [7:0]  he  [2][256];
  int          ecnt = 0;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) begin
        hv[i][j] = 1'b0;
        he[i][j] = 8'd0;
      end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          mst[i] = 0; mvn[i] = 0; merr[i] = 0;
          msum[i] = 0; mmm[i] = 0; fe[i] = ecnt;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          int t;
          bit tv;
          logic [7:0] te;
          t  = ecnt - lat[i];
          tv = 1'b0;
          te = 8'd0;
          if (t >= 0 && t > fe[i]) begin
            tv = hv[i][t % 256];
            te = he[i][t % 256];
          end
          mmm[i] = 1'b0;
          if (mst[i] == 1 && tv) begin
            mvn[i]  = mvn[i] + 1;
            msum[i] = msum[i] + 32'(z[i]);
            if (z[i] != te) begin
              mmm[i] = 1'b1;
              if (merr[i] != 32'hFFFF_FFFF) merr[i] = merr[i] + 1;
            end
          end
          hv[i][ecnt % 256] = (mst[i] == 1) && en[i];
          he[i][ecnt % 256] = 8'((9'(a[i]) + 9'(b[i])) % 256);
          if (mst[i] != 1 && st[i]) begin
            mst[i] = 1; mvn[i] = 0; merr[i] = 0;
            msum[i] = 0; mmm[i] = 0; fe[i] = ecnt;
          end else if (mst[i] == 1 && mvn[i] == 32'd4) begin
            mst[i] = 2;
          end
        end
        ecnt++;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.vectornum", i), vn[i], mvn[i]);
      chk($sformatf("u%0d.errors", i), er[i], merr[i]);
      chk($sformatf("u%0d.sum", i), sm[i], msum[i]);
      chk($sformatf("u%0d.mismatch", i), 32'(mm[i]), 32'(mmm[i]));
      chk($sformatf("u%0d.done", i), 32'(dn[i]), 32'(mst[i] == 2));
      chk($sformatf("u%0d.pass", i), 32'(ps[i]),
          32'(mst[i] == 2 && merr[i] == 0));
    end
    if (mm[0]) mmcnt0++;
  end

  task automatic do_start(input int i);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    chk("restart.vectornum", vn[i], 32'd0);
    chk("restart.done", 32'(dn[i]), 32'd0);
  endtask

  task automatic wait_done(input int i);
    for (int k = 0; k < 40; k++) begin
      if (dn[i]) break;
      @(negedge clk);
    end
    chk("done.reached", 32'(dn[i]), 32'd1);
  endtask

  task automatic check_run(input string nm, input int i,
                           input logic [31:0] e_vn, input logic [31:0] e_er,
                           input logic [31:0] e_sm, input logic e_ps);
    chk({nm, ".vectornum"}, vn[i], e_vn);
    chk({nm, ".errors"}, er[i], e_er);
    chk({nm, ".sum"}, sm[i], e_sm);
    chk({nm, ".pass"}, 32'(ps[i]), 32'(e_ps));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; en[i] = 0; a[i] = 0; b[i] = 0; z[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.vectornum", vn[0], 32'd0);
    chk("reset.done", 32'(dn[0]), 32'd0);
    chk("reset.pass", 32'(ps[0]), 32'd0);

    // 42+15=57 four times
    a[0] = 8'd42; b[0] = 8'd15; z[0] = 8'd57; en[0] = 1'b1;
    mmcnt0 = 0;
    do_start(0);
    wait_done(0);
    check_run("run1", 0, 32'd4, 32'd0, 32'd228, 1'b1);
    chk("run1.mm_pulses", 32'(mmcnt0), 32'd0);
    repeat (4) @(negedge clk);
    chk("hold.vectornum", vn[0], 32'd4);
    chk("hold.sum", sm[0], 32'd228);

    // restart from DONE reproduces the first run
    mmcnt0 = 0;
    do_start(0);
    wait_done(0);
    check_run("run2", 0, 32'd4, 32'd0, 32'd228, 1'b1);
    chk("run2.mm_pulses", 32'(mmcnt0), 32'd0);

    // second vector corrupted
    mmcnt0 = 0;
    do_start(0);
    for (int k = 0; k < 40 && !dn[0]; k++) begin
      z[0] = (k == 2) ? 8'd56 : 8'd57;
      @(negedge clk);
    end
    z[0] = 8'd57;
    @(negedge clk);
    check_run("bad2", 0, 32'd4, 32'd1, 32'd227, 1'b0);
    chk("bad2.mm_pulses", 32'(mmcnt0), 32'd1);

    // en toggling: four valid vectors take eight cycles
    do_start(0);
    for (int k = 0; k <= 8; k++) begin
      if (k == 7) begin
        chk("toggle.vn_k7", vn[0], 32'd3);
        chk("toggle.done_k7", 32'(dn[0]), 32'd0);
      end
      if (k == 8) begin
        chk("toggle.vn_k8", vn[0], 32'd4);
        chk("toggle.done_k8", 32'(dn[0]), 32'd1);
      end
      en[0] = (k % 2 == 0);
      @(negedge clk);
    end

    // asynchronous reset mid-run
    en[0] = 1'b1;
    do_start(0);
    repeat (3) @(negedge clk);
    chk("prereset.vectornum", vn[0], 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.vectornum", vn[0], 32'd0);
    chk("areset.errors", er[0], 32'd0);
    chk("areset.sum", sm[0], 32'd0);
    chk("areset.mismatch", 32'(mm[0]), 32'd0);
    chk("areset.done", 32'(dn[0]), 32'd0);
    chk("areset.pass", 32'(ps[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postreset.vectornum", vn[0], 32'd0);
    chk("postreset.done", 32'(dn[0]), 32'd0);
    do_start(0);
    wait_done(0);
    check_run("afterreset", 0, 32'd4, 32'd0, 32'd228, 1'b1);
    en[0] = 1'b0;

    // LAT=3: 200+100 wraps to 44
    a[1] = 8'd200; b[1] = 8'd100; z[1] = 8'd44; en[1] = 1'b1;
    do_start(1);
    for (int k = 0; k < 40 && !dn[1]; k++) begin
      if (k == 3) chk("lat3.vn_k3", vn[1], 32'd0);
      if (k == 4) chk("lat3.vn_k4", vn[1], 32'd1);
      @(negedge clk);
    end
    chk("lat3.done", 32'(dn[1]), 32'd1);
    check_run("lat3", 1, 32'd4, 32'd0, 32'd176, 1'b1);
    en[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("lat3.hold", vn[1], 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter LAT, default 1, meaning DUT latency in cycles from a/b sample to z valid; legal range 1..8.
REQ-002 Parameter NVEC, default 256, meaning number of checked vectors that completes a run; legal range 1..2^31.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a run; sampled only in IDLE or DONE.
REQ-006 en  input  1  a/b vector valid this cycle.
REQ-007 a  input  8  operand A driven to DUT.
REQ-008 b  input  8  operand B driven to DUT.
REQ-009 z  input  8  DUT result.
REQ-010 vectornum  output  32  count of checked vectors.
REQ-011 errors  output  32  count of mismatching vectors.
REQ-012 sum  output  32  running sum of checked z values.
REQ-013 mismatch  output  1  one-cycle pulse per mismatching vector.
REQ-014 done  output  1  run complete.
REQ-015 pass  output  1  done and errors == 0.

Function
REQ-016 The block SHALL implement states IDLE, RUN and DONE.
REQ-017 Transitions SHALL be: IDLE->RUN on start; RUN->DONE on the edge at which vectornum becomes NVEC; DONE->RUN on start. No other transitions.
REQ-018 On entry to RUN, the block SHALL clear vectornum, errors, sum, mismatch and all pipeline valid tags.
REQ-019 In RUN with en=1, the block SHALL push tag {valid=1, exp=(a+b) mod 256} into a LAT-deep shift pipeline; otherwise it SHALL push valid=0.
REQ-020 The pipeline SHALL shift every cycle regardless of en; tags pushed in IDLE/DONE SHALL be invalid.
REQ-021 When the tap tag is valid in RUN, the block SHALL compare z with exp in that cycle.
REQ-022 At that same clock edge: vectornum +1; sum += zero-extended z (mod 2^32); on mismatch errors +1.
REQ-023 errors SHALL saturate at 32'hFFFF_FFFF.
REQ-024 mismatch SHALL be registered: high for exactly the one cycle after a failing compare, otherwise low.
REQ-025 Valid tags emerging after the RUN->DONE edge SHALL be discarded without counting.
REQ-026 start asserted in RUN SHALL be ignored; start and a valid tap in the same DONE cycle SHALL restart per REQ-018, and that tap SHALL not be counted.
REQ-027 done SHALL be high exactly while in DONE; pass SHALL equal done && (errors == 0).
REQ-028 Counters and sum SHALL hold their values in DONE until the next start.

Reset
REQ-029 When reset_n is low, the block SHALL asynchronously force state IDLE, clear all pipeline tags, and drive vectornum=0, errors=0, sum=0, mismatch=0, done=0, pass=0.
REQ-030 Reset asserted mid-RUN SHALL abandon the run; no partial counts SHALL survive.
REQ-031 After reset_n rises, the block SHALL stay in IDLE until start.

Structure
REQ-032 A shared package checker_pkg SHALL hold the state enum (IDLE, RUN, DONE), the tag struct {valid, exp[7:0]}, and the LAT_MAX=8 constant.
REQ-033 The tag pipeline SHALL be a sub-module delay_line, parameterised by depth and with a synchronous flush input.
REQ-034 The remaining logic (FSM, comparator, counters) SHALL reside in result_checker.

Verification
REQ-035 LAT=1, NVEC=4, a=42, b=15, en=1, z=57 from the first tap -> vectornum=4, errors=0, sum=228, done=1, pass=1, mismatch never high.
REQ-036 Same setup with z=56 on the 2nd vector only -> errors=1, a single mismatch pulse one cycle after that compare, sum=227, pass=0.
REQ-037 LAT=3, a=200, b=100, en=1 -> exp=44; z=44 passes and z=300-truncated cases do not false-fail; counting starts exactly 3 cycles after the first en.
REQ-038 NVEC=4, en toggling 1,0,1,0,... -> only en=1 cycles are counted; done asserts after the 4th valid compare, not after 4 cycles.
REQ-039 reset_n pulled low after 2 vectors in RUN -> all outputs 0 immediately (asynchronously), state IDLE; a new start begins counting from 0.
REQ-040 In DONE, assert start -> counters cleared next edge, done=0, and a second full run reproduces the REQ-035 results.
